seq_fetch_unit: RTL

Multi-cycle instruction fetch stage for the Y86-64 SEQ processor, directly downstream of the PC update stage. It accepts the new PC and reads the instruction one byte at a time over a handshaked byte-wide instruction-memory port. It then presents the decoded fields icode, ifun, rA, rB, valC and valP, with a one-cycle valid strobe, to decode/execute.

---
 rtl/seq_fetch_unit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/seq_fetch_unit.sv
// seq_fetch_unit: byte-serial Y86-64 instruction fetch over a handshaked
// byte-wide memory port, presenting decoded fields with a one-cycle strobe.
module seq_fetch_unit #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [63:0] pc_in,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic [7:0]  imem_rdata,
   input  logic        imem_ack,
   input  logic        imem_err,
   output logic        busy,
   output logic [3:0]  icode,
   output logic [3:0]  ifun,
   output logic [3:0]  rA,
   output logic [3:0]  rB,
   output logic [63:0] valC,
   output logic [63:0] valP,
   output logic        instr_valid,
   output logic        instr_invalid,
   output logic        fetch_error
);
   typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
   state_t state;
   logic [63:0] pc;
   logic [3:0]  byte_cnt, len, vc_start, vc_idx, b0_len;
   logic [5:0]  vc_sh;
   logic [31:0] wait_cnt;
   logic        has_reg, has_valc, timeout_hit;

   function automatic logic [3:0] len_of(input logic [3:0] ic);
      return (ic inside {4'h3, 4'h4, 4'h5}) ? 4'd10 :
             (ic inside {4'h7, 4'h8}) ? 4'd9 :
             (ic inside {4'h2, 4'h6, 4'hA, 4'hB}) ? 4'd2 : 4'd1;
   endfunction

   always_comb begin
      b0_len = len_of(imem_rdata[7:4]);
      has_reg = icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
      has_valc = icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
      vc_start = (icode inside {4'h3, 4'h4, 4'h5}) ? 4'd2 : 4'd1;
      vc_idx = byte_cnt - vc_start;
      vc_sh = 6'({vc_idx, 3'b000});
      timeout_hit = (TIMEOUT != 0) && (wait_cnt == TIMEOUT - 1);
   end

   assign imem_req = (state == FETCH);
   assign busy = (state != IDLE);
   assign instr_valid = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pc <= '0;
         imem_addr <= '0;
         byte_cnt <= '0;
         len <= '0;
         wait_cnt <= '0;
         icode <= '0;
         ifun <= '0;
         rA <= 4'hF;
         rB <= 4'hF;
         valC <= '0;
         valP <= '0;
         instr_invalid <= 1'b0;
         fetch_error <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               pc <= pc_in;
               imem_addr <= pc_in;
               byte_cnt <= '0;
               wait_cnt <= '0;
               rA <= 4'hF;
               rB <= 4'hF;
               valC <= '0;
               instr_invalid <= 1'b0;
               fetch_error <= 1'b0;
               state <= FETCH;
            end
            FETCH: if (imem_ack) begin
               wait_cnt <= '0;
               if (imem_err) begin
                  fetch_error <= 1'b1;
                  valP <= pc;
                  state <= DONE;
               end else begin
                  imem_addr <= imem_addr + 64'd1;
                  byte_cnt <= byte_cnt + 4'd1;
                  if (byte_cnt == 4'd0) begin
                     icode <= imem_rdata[7:4];
                     ifun <= imem_rdata[3:0];
                     len <= b0_len;
                     instr_invalid <= imem_rdata[7:4] > 4'hB;
                     if (b0_len == 4'd1) begin
                        valP <= pc + 64'd1;
                        state <= DONE;
                     end
                  end else begin
                     if (has_reg && byte_cnt == 4'd1) begin
                        rA <= imem_rdata[7:4];
                        rB <= imem_rdata[3:0];
                     end
                     // valC bytes arrive least-significant first
                     if (has_valc && byte_cnt >= vc_start)
                        valC[vc_sh +: 8] <= imem_rdata;
                     if (byte_cnt == len - 4'd1) begin
                        valP <= pc + 64'(len);
                        state <= DONE;
                     end
                  end
               end
            end else if (timeout_hit) begin
               fetch_error <= 1'b1;
               valP <= pc;
               state <= DONE;
            end else begin
               wait_cnt <= wait_cnt + 32'd1;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
